// File: rtl/exe_alu_status.sv
// rtl/exe_alu_status.sv - execute-stage ALU with NZCV status register and EXE/MEM pipeline register
module exe_alu_status #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [3:0]            exe_cmd,
    input  logic                  s_bit,
    input  logic [DATA_W-1:0]     val1,
    input  logic [DATA_W-1:0]     val2,
    input  logic [DATA_W-1:0]     st_val_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic [DATA_W-1:0]     alu_res,
    output logic [DATA_W-1:0]     st_val,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  valid_out,
    output logic [3:0]            status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam int         MSB     = DATA_W - 1;

    logic              c_in;
    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   wide;
    logic              c_new;
    logic              v_new;
    logic              cmd_defined;
    logic              status_load;

    assign c_in = status[1];

    always_comb begin
        res         = '0;
        wide        = '0;
        c_new       = status[1];
        v_new       = status[0];
        cmd_defined = 1'b1;
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                wide  = {1'b0, val1} + {1'b0, val2}
                      + {{DATA_W{1'b0}}, (exe_cmd == CMD_ADC) & c_in};
                res   = wide[MSB:0];
                c_new = wide[DATA_W];
                v_new = (val1[MSB] == val2[MSB]) && (res[MSB] != val1[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // Carry is the inverse of the borrow out of the 33-bit difference.
                wide  = {1'b0, val1} - {1'b0, val2}
                      - {{DATA_W{1'b0}}, (exe_cmd == CMD_SBC) & ~c_in};
                res   = wide[MSB:0];
                c_new = ~wide[DATA_W];
                v_new = (val1[MSB] != val2[MSB]) && (res[MSB] != val1[MSB]);
            end
            default: cmd_defined = 1'b0;
        endcase
    end

    assign status_load = valid_in & s_bit & cmd_defined;

    // Flush kills only the controls; data fields keep their last captured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res   <= '0;
            st_val    <= '0;
            dest      <= '0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            valid_out <= 1'b0;
            status    <= 4'b0000;
        end else if (flush) begin
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            valid_out <= 1'b0;
        end else if (!freeze) begin
            alu_res   <= res;
            st_val    <= st_val_in;
            dest      <= dest_in;
            wb_en     <= valid_in & wb_en_in;
            mem_r_en  <= valid_in & mem_r_en_in;
            mem_w_en  <= valid_in & mem_w_en_in;
            valid_out <= valid_in;
            if (status_load) begin
                status <= {res[MSB], (res == '0), c_new, v_new};
            end
        end
    end

endmodule

// File: tb/tb_exe_alu_status.sv
// tb/tb_exe_alu_status.sv - randomized and directed check of exe_alu_status against an arithmetic reference model
module tb_exe_alu_status;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  exe_cmd = 4'd0;
    logic        s_bit = 1'b0;
    logic [31:0] val1 = '0;
    logic [31:0] val2 = '0;
    logic [31:0] st_val_in = '0;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic        mem_w_en_in = 1'b0;
    logic [3:0]  dest_in = '0;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  dest;
    logic        valid_out;
    logic [3:0]  status;

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;

    logic [31:0] e_res, e_st;
    logic [3:0]  e_dest, e_status, e_ctrl;

    exe_alu_status #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .exe_cmd(exe_cmd), .s_bit(s_bit),
        .val1(val1), .val2(val2), .st_val_in(st_val_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .dest_in(dest_in), .alu_res(alu_res), .st_val(st_val),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .dest(dest), .valid_out(valid_out), .status(status)
    );

    always #5 clk = ~clk;

    // Flags from plain integer arithmetic: carry/borrow from unsigned range, V from signed range.
    function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] st, output logic [31:0] r,
                                    output logic [3:0] nst, output bit def);
        longint ua, ub, sa, sb, full, sfull, k;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        nst = st;
        def = 1'b1;
        r = '0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd2, 4'd3: begin
                k = (cmd == 4'd3) ? longint'(st[1]) : 0;
                full = ua + ub + k;
                sfull = sa + sb + k;
                r = full[31:0];
                nst[1] = (full > 64'sd4294967295);
                nst[0] = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                k = (cmd == 4'd5) ? longint'(!st[1]) : 0;
                full = ua - ub - k;
                sfull = sa - sb - k;
                r = full[31:0];
                nst[1] = (full >= 0);
                nst[0] = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
            end
            default: def = 1'b0;
        endcase
        if (def) begin
            nst[3] = r[31];
            nst[2] = (r == 32'd0);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("alu_res", alu_res, e_res);
        chk("st_val", st_val, e_st);
        chk("dest", {28'd0, dest}, {28'd0, e_dest});
        chk("ctrl", {28'd0, valid_out, wb_en, mem_r_en, mem_w_en}, {28'd0, e_ctrl});
        chk("status", {28'd0, status}, {28'd0, e_status});
    endtask

    task automatic model_reset();
        e_res = '0; e_st = '0; e_dest = '0; e_status = '0; e_ctrl = '0;
    endtask

    task automatic step();
        logic [31:0] r;
        logic [3:0]  nst;
        bit          def;
        @(posedge clk);
        ref_alu(exe_cmd, val1, val2, e_status, r, nst, def);
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            e_ctrl = '0;
        end else if (!freeze) begin
            e_res = r;
            e_st = st_val_in;
            e_dest = dest_in;
            e_ctrl = valid_in ? {1'b1, wb_en_in, mem_r_en_in, mem_w_en_in} : 4'b0000;
            if (valid_in && s_bit && def) e_status = nst;
        end
        #1;
        vectors++;
        chk_all();
    endtask

    task automatic apply(input logic [3:0] cmd, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic v, input logic fz, input logic fl);
        exe_cmd = cmd; s_bit = s; val1 = a; val2 = b;
        valid_in = v; freeze = fz; flush = fl;
        st_val_in = $urandom;
        dest_in = 4'($urandom);
        {wb_en_in, mem_r_en_in, mem_w_en_in} = 3'($urandom);
        step();
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_reset();
        // Reset held with random inputs toggling
        for (int i = 0; i < 3; i++) apply(4'($urandom), 1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        apply(4'd2, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
        chk("idle_valid", {31'd0, valid_out}, 32'd0);

        // ADDS then ADC
        apply(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
        chk("adds_res", alu_res, 32'd0);
        chk("adds_status", {28'd0, status}, 32'h6);
        apply(4'd3, 1'b0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("adc_res", alu_res, 32'd6);
        chk("adc_status", {28'd0, status}, 32'h6);

        // SUBS overflow, then ORR keeps C/V
        apply(4'd4, 1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0);
        chk("subs_ovf_res", alu_res, 32'h7FFF_FFFF);
        chk("subs_ovf_status", {28'd0, status}, 32'h3);
        apply(4'd7, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("orr_res", alu_res, 32'd0);
        chk("orr_status", {28'd0, status}, 32'h7);
        apply(4'd4, 1'b1, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
        chk("subs_neg_res", alu_res, 32'hFFFF_FFFE);
        chk("subs_neg_status", {28'd0, status}, 32'h8);
        apply(4'd4, 1'b1, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
        chk("subs_eq_status", {28'd0, status}, 32'h6);

        // Freeze two cycles, then release
        apply(4'd2, 1'b0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        apply(4'd2, 1'b0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        chk("freeze_hold", alu_res, 32'd0);
        apply(4'd2, 1'b0, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        chk("freeze_release", alu_res, 32'd2);

        // Flush wins over freeze
        apply(4'd4, 1'b1, 32'd1, 32'd9, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_status", {28'd0, status}, 32'h6);

        // Undefined command with s_bit set
        apply(4'hF, 1'b1, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);
        chk("undef_res", alu_res, 32'd0);
        chk("undef_status", {28'd0, status}, 32'h6);
        chk("undef_valid", {31'd0, valid_out}, 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            apply(4'($urandom), 1'($urandom), rand_op(), rand_op(),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset mid-cycle discards the in-flight state
        apply(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        #3;
        rst_n = 1'b1;
        apply(4'd1, 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_alu_status.md
Name: exe_alu_status

Overview:
- Execute-stage ALU that consumes val1 (Rn) and the shifted/immediate val2 operand, then produces the ALU result and NZCV flags.
- Owns the architectural status register (CPSR flags).
- Registers result and control into the EXE/MEM pipeline boundary, with freeze (hazard stall) and flush (branch kill) support.
- Sits directly downstream of the val2 operand generator and upstream of the memory stage.

Parameters:
- DATA_W, 32, datapath width of val1, val2 and result.
- REG_ADDR_W, 4, width of the destination register index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- freeze  input  1  hold all registered state this cycle.
- flush  input  1  insert a bubble into EXE/MEM this cycle.
- valid_in  input  1  instruction present in EXE.
- exe_cmd  input  4  ALU operation code.
- s_bit  input  1  update status flags.
- val1  input  DATA_W  first operand (Rn).
- val2  input  DATA_W  second operand from the val2 generator.
- st_val_in  input  DATA_W  store data (Rd value).
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  pass-through controls.
- dest_in  input  REG_ADDR_W  destination register.
- alu_res  output  DATA_W  registered ALU result.
- st_val  output  DATA_W  registered store data.
- wb_en, mem_r_en, mem_w_en  output  1 each  registered controls.
- dest  output  REG_ADDR_W  registered destination.
- valid_out  output  1  registered valid.
- status  output  4  status register {N,Z,C,V}; combinationally drives c_in to the ALU.

Behaviour:
- Reset: rst_n low asynchronously clears alu_res, st_val, dest, status and all control outputs to 0, including valid_out. Reset mid-operation discards the in-flight instruction.
- Latency: 1 cycle. Inputs sampled at edge k appear on outputs after edge k.

exe_cmd encoding and operations (c = status[1]):
- 0001 MOV: res = val2.
- 1001 MVN: res = ~val2.
- 0010 ADD: val1 + val2.
- 0011 ADC: val1 + val2 + c.
- 0100 SUB: val1 - val2.
- 0101 SBC: val1 - val2 - !c.
- 0110 AND.
- 0111 ORR.
- 1000 EOR.
- Any other code: res = 0, no flag update even if s_bit = 1.

Flag rules:
- N = res[31].
- Z = (res == 0).
- Add ops: C = carry out of bit 31, computed on a 33-bit sum. V = operands same sign and result sign differs.
- Sub ops: C = NOT borrow (1 when no borrow), so SUB 5-5 gives C=1. V = operand signs differ and result sign differs from val1.
- Logical/move ops: N and Z update; C and V are held.

Status update:
- status loads the new flags on the edge only when valid_in & s_bit & !freeze & !flush and exe_cmd is defined.
- The following instruction sees the new flags on the next cycle with no extra delay. Back-to-back ADDS then ADC works.

Pipeline register priority, evaluated each edge:
1. flush = 1 (wins over freeze): valid_out, wb_en, mem_r_en, mem_w_en go to 0. Data fields hold their previous value. status is not updated.
2. freeze = 1: every register holds, including status.
3. Otherwise: capture all inputs and the computed result. If valid_in = 0, capture valid_out = 0 and all enables = 0.

Other rules:
- Memory ops (LDR/STR) arrive as exe_cmd 0010 with s_bit = 0; the address is val1 + val2.
- Arithmetic wraps modulo 2^32. There is no saturation.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release.
  -> All outputs 0, status=0000. valid_out stays 0 until the first valid cycle.
- ADDS then ADC: val1=0xFFFFFFFF, val2=1, exe_cmd=0010, s=1; next cycle ADC with val1=2, val2=3, s=0.
  -> First result 0x00000000, status=0110 (Z=1, C=1). Second result 6, status unchanged.
- SUBS overflow: val1=0x80000000, val2=1, SUB, s=1.
  -> Result 0x7FFFFFFF, status=0011 (N=0, Z=0, C=1, V=1).
  - SUBS 3-5: result 0xFFFFFFFE, status=1000 (N=1, C=0).
- Logical holds C/V: preset status=0011, then ORR val1=0, val2=0, s=1.
  -> Result 0, status=0111 (Z set, C/V kept).
- Freeze/flush: issue ADD 1+1 with freeze=1 for 2 cycles, then release.
  -> Outputs hold the prior values during freeze, then alu_res=2 after release.
  - Issue SUBS with flush=1 and freeze=1 simultaneously -> valid_out=0, enables=0, status unchanged.
- Undefined cmd: exe_cmd=1111, s=1, valid_in=1.
  -> alu_res=0, status unchanged, controls pass through.
